// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_if
// Description : EX/MEM inputs, hazard controls and MEM/WB outputs of the
//               memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic [31:0] ALUresultM;
    logic [31:0] WriteDataM;
    logic [4:0]  WriteRegM;
    logic        StallW;
    logic        FlushW;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUresultW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        AlignErr;
    logic [31:0] ErrAddr;

    modport master (
        output RegWriteM, MemtoRegM, MemWriteM, ALUresultM, WriteDataM, WriteRegM,
        output StallW, FlushW,
        input  RegWriteW, MemtoRegW, ReadDataW, ALUresultW, WriteRegW, ResultW,
        input  AlignErr, ErrAddr
    );

    modport slave (
        input  RegWriteM, MemtoRegM, MemWriteM, ALUresultM, WriteDataM, WriteRegM,
        input  StallW, FlushW,
        output RegWriteW, MemtoRegW, ReadDataW, ALUresultW, WriteRegW, ResultW,
        output AlignErr, ErrAddr
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : Word-wide data memory access plus MEM/WB pipeline register,
//               with stall/flush support and a sticky misalignment trap.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8
) (
    input  wire logic     CLK,
    input  wire logic     RSTn,
    mem_wb_stage_if.slave bus
);

    logic [31:0]          r_mem [DEPTH_WORDS];
    logic [ADDR_BITS-1:0] w_index;
    logic [31:0]          w_readData;
    logic                 w_mis;
    logic                 w_store;

    logic                 r_regWriteW;
    logic                 r_memtoRegW;
    logic [31:0]          r_readDataW;
    logic [31:0]          r_aluResultW;
    logic [4:0]           r_writeRegW;
    logic                 r_alignErr;
    logic [31:0]          r_errAddr;

    // Upper address bits are ignored, so out-of-range addresses wrap.
    assign w_index    = bus.ALUresultM[ADDR_BITS+1:2];
    assign w_readData = r_mem[w_index];
    assign w_mis      = (bus.MemWriteM | bus.MemtoRegM) & (bus.ALUresultM[1:0] != 2'b00);
    assign w_store    = bus.MemWriteM & ~w_mis & ~bus.StallW & ~bus.FlushW;

    // Contents survive reset; a store presented while reset is held is dropped.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
        end else if (w_store) begin
            r_mem[w_index] <= bus.WriteDataM;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_regWriteW  <= 1'b0;
            r_memtoRegW  <= 1'b0;
            r_readDataW  <= 32'd0;
            r_aluResultW <= 32'd0;
            r_writeRegW  <= 5'd0;
            r_alignErr   <= 1'b0;
            r_errAddr    <= 32'd0;
        end else begin
            if (bus.FlushW) begin
                r_regWriteW  <= 1'b0;
                r_memtoRegW  <= 1'b0;
                r_readDataW  <= 32'd0;
                r_aluResultW <= 32'd0;
                r_writeRegW  <= 5'd0;
            end else if (!bus.StallW) begin
                // A misaligned access becomes a non-writing bubble.
                r_regWriteW  <= bus.RegWriteM & ~w_mis;
                r_memtoRegW  <= bus.MemtoRegM & ~w_mis;
                r_readDataW  <= w_readData;
                r_aluResultW <= bus.ALUresultM;
                r_writeRegW  <= bus.WriteRegM;
            end
            if (w_mis && !bus.FlushW && !r_alignErr) begin
                r_alignErr <= 1'b1;
                r_errAddr  <= bus.ALUresultM;
            end
        end
    end

    assign bus.RegWriteW  = r_regWriteW;
    assign bus.MemtoRegW  = r_memtoRegW;
    assign bus.ReadDataW  = r_readDataW;
    assign bus.ALUresultW = r_aluResultW;
    assign bus.WriteRegW  = r_writeRegW;
    assign bus.ResultW    = r_memtoRegW ? r_readDataW : r_aluResultW;
    assign bus.AlignErr   = r_alignErr;
    assign bus.ErrAddr    = r_errAddr;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Scoreboard bench for mem_wb_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        ae;
        logic [31:0] ea;
    } exp_t;

    logic CLK;
    logic RSTn;
    int   checks;
    int   errors;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.DEPTH_WORDS(256), .ADDR_BITS(8)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    logic [31:0] mMem [256];
    exp_t        mW;
    exp_t        expq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference behaviour of one clock edge with RSTn high.
    task automatic modelStep(input logic rw, mtr, mw, input logic [31:0] alu, wd,
                             input logic [4:0] wr, input logic st, fl);
        logic   mis;
        int     idx;
        mis = (mw || mtr) && (alu % 4 != 0);
        idx = int'((alu / 4) % 256);
        if (fl) begin
            mW.rw = 0; mW.mtr = 0; mW.rd = 0; mW.alu = 0; mW.wr = 0;
        end else if (!st) begin
            mW.rw  = rw && !mis;
            mW.mtr = mtr && !mis;
            mW.rd  = mMem[idx];
            mW.alu = alu;
            mW.wr  = wr;
        end
        if (mis && !fl && !mW.ae) begin
            mW.ae = 1'b1;
            mW.ea = alu;
        end
        if (mw && !mis && !st && !fl) mMem[idx] = wd;
    endtask

    task automatic cyc(input logic rw, mtr, mw, input logic [31:0] alu, wd,
                       input logic [4:0] wr, input logic st, fl);
        bus.RegWriteM  = rw;
        bus.MemtoRegM  = mtr;
        bus.MemWriteM  = mw;
        bus.ALUresultM = alu;
        bus.WriteDataM = wd;
        bus.WriteRegM  = wr;
        bus.StallW     = st;
        bus.FlushW     = fl;
        modelStep(rw, mtr, mw, alu, wd, wr, st, fl);
        expq.push_back(mW);
        @(posedge CLK);
        #2;
    endtask

    task automatic chkZero(input string nm);
        chk({nm, "_RegWriteW"},  32'(bus.RegWriteW), 32'd0);
        chk({nm, "_MemtoRegW"},  32'(bus.MemtoRegW), 32'd0);
        chk({nm, "_ReadDataW"},  bus.ReadDataW, 32'd0);
        chk({nm, "_ALUresultW"}, bus.ALUresultW, 32'd0);
        chk({nm, "_WriteRegW"},  32'(bus.WriteRegW), 32'd0);
        chk({nm, "_ResultW"},    bus.ResultW, 32'd0);
        chk({nm, "_AlignErr"},   32'(bus.AlignErr), 32'd0);
        chk({nm, "_ErrAddr"},    bus.ErrAddr, 32'd0);
    endtask

    // Monitor: one expected W state per clock edge, compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("RegWriteW",  32'(bus.RegWriteW), 32'(e.rw));
                chk("MemtoRegW",  32'(bus.MemtoRegW), 32'(e.mtr));
                chk("ReadDataW",  bus.ReadDataW, e.rd);
                chk("ALUresultW", bus.ALUresultW, e.alu);
                chk("WriteRegW",  32'(bus.WriteRegW), 32'(e.wr));
                chk("ResultW",    bus.ResultW, e.mtr ? e.rd : e.alu);
                chk("AlignErr",   32'(bus.AlignErr), 32'(e.ae));
                chk("ErrAddr",    bus.ErrAddr, e.ea);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        mw, mtr;
        checks = 0;
        errors = 0;
        mW     = '0;
        RSTn   = 1'b0;
        bus.RegWriteM = 0; bus.MemtoRegM = 0; bus.MemWriteM = 0;
        bus.ALUresultM = 0; bus.WriteDataM = 0; bus.WriteRegM = 0;
        bus.StallW = 0; bus.FlushW = 0;
        #3;
        chkZero("reset0");
        @(posedge CLK);
        #2;
        RSTn = 1'b1;

        // Fill every word so the model knows the whole array.
        for (int i = 0; i < 256; i++) cyc(0, 0, 1, 32'(i * 4), $urandom, 0, 0, 0);

        // Store then load the same word on the next cycle.
        cyc(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        cyc(1, 1, 0, 32'h10, 32'h0, 5'd5, 0, 0);
        chk("st_ld_ResultW", bus.ResultW, 32'hDEADBEEF);
        chk("st_ld_WriteRegW", 32'(bus.WriteRegW), 32'd5);

        // Address wrap.
        cyc(0, 0, 1, 32'h400, 32'h12345678, 0, 0, 0);
        cyc(1, 1, 0, 32'h0, 32'h0, 5'd7, 0, 0);
        chk("wrap_ReadDataW", bus.ReadDataW, 32'h12345678);

        // Stall holds everything, then exactly one write on release.
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'h20, 32'hAAAA5555, 5'd9, 1, 0);
        cyc(1, 0, 1, 32'h20, 32'hAAAA5555, 5'd9, 0, 0);
        cyc(1, 1, 0, 32'h20, 32'h0, 5'd2, 0, 0);
        chk("stall_ReadDataW", bus.ReadDataW, 32'hAAAA5555);

        // Flush beats stall and suppresses the store.
        cyc(1, 0, 1, 32'h24, 32'h0BADF00D, 5'd3, 1, 1);
        cyc(1, 1, 0, 32'h24, 32'h0, 5'd4, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            a   = $urandom;
            a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            mw  = ($urandom_range(0, 2) == 0);
            mtr = !mw && ($urandom_range(0, 1) == 0);
            cyc(1'($urandom), mtr, mw, a, $urandom, 5'($urandom),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset mid-cycle with a store presented across the edge.
        d = mMem[12];
        bus.MemWriteM = 1; bus.MemtoRegM = 0; bus.ALUresultM = 32'h30;
        bus.WriteDataM = ~d; bus.StallW = 0; bus.FlushW = 0;
        #3;
        RSTn = 1'b0;
        #1;
        chkZero("reset_async");
        @(posedge CLK);
        #2;
        chkZero("reset_held");
        RSTn = 1'b1;
        mW = '0;
        cyc(1, 1, 0, 32'h30, 32'h0, 5'd1, 0, 0);
        chk("reset_no_write", bus.ReadDataW, d);

        // Misaligned store then misaligned load.
        d = mMem[4];
        cyc(1, 0, 1, 32'h13, 32'h55555555, 5'd6, 0, 0);
        chk("mis1_AlignErr", 32'(bus.AlignErr), 32'd1);
        chk("mis1_ErrAddr", bus.ErrAddr, 32'h13);
        cyc(1, 1, 0, 32'h22, 32'h0, 5'd8, 0, 0);
        chk("mis2_ErrAddr", bus.ErrAddr, 32'h13);
        chk("mis2_RegWriteW", 32'(bus.RegWriteW), 32'd0);
        cyc(1, 1, 0, 32'h10, 32'h0, 5'd8, 0, 0);
        chk("mis_no_write", bus.ReadDataW, d);

        cyc(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge CLK);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS core. Consumes the EX/MEM register outputs (M-stage controls, ALU result, store data, destination register), performs the word-wide data-memory access, and registers everything the writeback stage needs. It also supports hazard-unit stall/flush and traps misaligned accesses.

## Interface
- DEPTH_WORDS, 256: data-memory depth in 32-bit words (power of two).
- ADDR_BITS, 8: log2(DEPTH_WORDS); word index = ALUresultM[ADDR_BITS+1:2].

- CLK  in  1  clock; all state updates on posedge.
- RSTn  in  1  reset, asynchronous, active-low.
- RegWriteM, MemtoRegM, MemWriteM  in  1 each  M-stage controls from EX/MEM.
- ALUresultM  in  32  byte address for loads/stores; pass-through result otherwise.
- WriteDataM  in  32  store data.
- WriteRegM  in  5  destination register.
- StallW  in  1  hold the MEM/WB register and block the store.
- FlushW  in  1  squash the M-stage instruction and load a bubble.
- RegWriteW, MemtoRegW  out  1 each  registered controls.
- ReadDataW, ALUresultW  out  32 each  registered load data and ALU result.
- WriteRegW  out  5  registered destination.
- ResultW  out  32  combinational: MemtoRegW ? ReadDataW : ALUresultW.
- AlignErr  out  1  sticky misaligned-access flag.
- ErrAddr  out  32  address of the first misaligned access.

## Operation
- Memory: DEPTH_WORDS x 32 array. Contents are not reset. Read is combinational on the word index. Write is synchronous.
- Address above the array range wraps modulo DEPTH_WORDS. Only the index bits are used.
- Misaligned access (mis): (MemWriteM | MemtoRegM) & (ALUresultM[1:0] != 0).
- Store commit: the write happens at posedge iff MemWriteM & !mis & !StallW & !FlushW.
- Priority is RSTn low > FlushW > StallW > normal.
- Normal cycle: RegWriteW <= RegWriteM & !mis; MemtoRegW <= MemtoRegM & !mis; ReadDataW <= mem[index]; ALUresultW <= ALUresultM; WriteRegW <= WriteRegM.
- StallW=1 (no flush): every W register holds its value and no store occurs. mis still updates AlignErr/ErrAddr.
- FlushW=1: all W registers load 0, the store is suppressed, and AlignErr/ErrAddr are not updated.
- AlignErr/ErrAddr: on the first clock with mis & !FlushW, set AlignErr=1 and ErrAddr<=ALUresultM. Later errors do not overwrite ErrAddr. Both clear only on reset.
- A load following a store to the same word in the next cycle reads the new data, because the write lands at the edge between them.
- A misaligned instruction becomes a non-writing bubble in W with ALUresultW still captured.

## Timing
- Reset (async, immediate on RSTn fall): RegWriteW=0, MemtoRegW=0, ReadDataW=0, ALUresultW=0, WriteRegW=0, AlignErr=0, ErrAddr=0. ResultW consequently reads 0.
- Release is synchronous in effect: the first capture happens at the first posedge with RSTn=1.
- Latency: M inputs appear on W outputs 1 cycle later. The store takes effect at that same edge.
- ResultW has zero latency from the W registers and contains no combinational path from M inputs.
- Reset mid-store: if RSTn is low at the edge, no write occurs. Memory keeps its prior contents.
- Simultaneous StallW and FlushW: the flush wins.

## Test plan
- Reset: RSTn=0 mid-cycle -> all W outputs and AlignErr/ErrAddr go to 0 at once, without waiting for a clock edge.
- Store then load: store 0xDEADBEEF to addr 0x10, then the next cycle load 0x10 with MemtoRegM=1, WriteRegM=5 -> 1 cycle later ResultW=0xDEADBEEF, WriteRegW=5, RegWriteW=1.
- Wrap: store 0x12345678 at addr 0x400 (index 0 with DEPTH=256), then load 0x0 -> ReadDataW=0x12345678.
- Stall: StallW=1 for 3 cycles while a store of 0xAAAA5555 to 0x20 is presented -> W outputs frozen, mem[8] unchanged. Release -> exactly one write, then W updates.
- Flush: FlushW=1 and StallW=1 with a store to 0x24 -> W outputs 0 next cycle, mem[9] unchanged.
- Misalign: store to 0x13, then load from 0x22 -> AlignErr=1 and ErrAddr=0x13 after the first, no memory write, RegWriteW=0 for both. ErrAddr stays 0x13 after the second.
